// File: rtl/dispense_controller.sv
// rtl/dispense_controller.sv - vend sequencer with motor pulse, change payout and stock tracking
module dispense_controller #(
    parameter int PULSE_CYC  = 4,
    parameter int INIT_STOCK = 8,
    parameter int PRICE_N    = 5
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       vend_soda,
    input  logic       vend_diet,
    input  logic [3:0] change_n,
    input  logic       restock,
    output logic       soda_motor,
    output logic       diet_motor,
    output logic       nickel_out,
    output logic       busy,
    output logic       req_ack,
    output logic       reject,
    output logic       done,
    output logic       soda_empty,
    output logic       diet_empty
);

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        GAP,
        CHANGE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [3:0] soda_stock;
    logic [3:0] diet_stock;
    logic [3:0] pulse_cnt;
    logic [4:0] nick_cnt;
    logic       nick_phase;
    logic       sel_diet;

    logic       accept;
    logic       pick_diet;
    logic       sold_out;
    logic [4:0] refund;

    // Restock wins over a same-cycle vend; soda wins over diet.
    assign accept     = (state == IDLE) && !restock && (vend_soda || vend_diet);
    assign pick_diet  = !vend_soda;
    assign sold_out   = pick_diet ? (diet_stock == 4'd0) : (soda_stock == 4'd0);
    assign refund     = {1'b0, change_n} + 5'(PRICE_N);

    assign soda_empty = (soda_stock == 4'd0);
    assign diet_empty = (diet_stock == 4'd0);

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore outputs; sold-out requests skip the motor phase.
    always_comb begin
        state_nx   = state;
        soda_motor = 1'b0;
        diet_motor = 1'b0;
        nickel_out = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = sold_out ? GAP : MOTOR;
                end
            end
            MOTOR: begin
                busy       = 1'b1;
                soda_motor = !sel_diet;
                diet_motor = sel_diet;
                if (pulse_cnt == 4'd0) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                busy     = 1'b1;
                state_nx = CHANGE;
            end
            CHANGE: begin
                busy       = 1'b1;
                nickel_out = (nick_cnt != 5'd0) && !nick_phase;
                if ((nick_cnt == 5'd0) || (nick_phase && (nick_cnt == 5'd1))) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Stock, request latch, motor timer and change counter.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            soda_stock <= 4'(INIT_STOCK);
            diet_stock <= 4'(INIT_STOCK);
            pulse_cnt  <= 4'd0;
            nick_cnt   <= 5'd0;
            nick_phase <= 1'b0;
            sel_diet   <= 1'b0;
            req_ack    <= 1'b0;
            reject     <= 1'b0;
        end else begin
            req_ack <= accept;
            reject  <= accept && sold_out;

            if ((state == IDLE) && restock) begin
                soda_stock <= 4'(INIT_STOCK);
                diet_stock <= 4'(INIT_STOCK);
            end

            if (accept) begin
                sel_diet   <= pick_diet;
                pulse_cnt  <= 4'(PULSE_CYC - 1);
                nick_cnt   <= sold_out ? refund : {1'b0, change_n};
                nick_phase <= 1'b0;
                // sold_out guards the decrement, so stock never wraps below zero
                if (!sold_out) begin
                    if (pick_diet) begin
                        diet_stock <= diet_stock - 4'd1;
                    end else begin
                        soda_stock <= soda_stock - 4'd1;
                    end
                end
            end

            if ((state == MOTOR) && (pulse_cnt != 4'd0)) begin
                pulse_cnt <= pulse_cnt - 4'd1;
            end

            // One nickel = one high cycle followed by one low cycle.
            if ((state == CHANGE) && (nick_cnt != 5'd0)) begin
                if (nick_phase) begin
                    nick_phase <= 1'b0;
                    nick_cnt   <= nick_cnt - 5'd1;
                end else begin
                    nick_phase <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dispense_controller.md
DISPENSE_CONTROLLER -- requirements
Module: dispense_controller

Interface
REQ-001 The block SHALL expose parameters, one per line: name, default, meaning.
- PULSE_CYC, 4, motor-on cycles per vend (1..15)
- INIT_STOCK, 8, per-product stock loaded at reset/restock (0..15)
- PRICE_N, 5, product price in nickels used for sold-out refund
REQ-002 The block SHALL have these ports (name, direction, width, meaning); one clock; reset is asynchronous and active-low.
- CLK, in, 1, rising-edge clock
- rst, in, 1, asynchronous active-low reset
- vend_soda, in, 1, one-cycle request to dispense soda
- vend_diet, in, 1, one-cycle request to dispense diet
- change_n, in, 4, nickels of change owed, sampled with an accepted request
- restock, in, 1, one-cycle pulse reloading both stocks
- soda_motor, out, 1, soda dispense solenoid
- diet_motor, out, 1, diet dispense solenoid
- nickel_out, out, 1, hopper strobe, one nickel per high cycle
- busy, out, 1, high in every non-IDLE state
- req_ack, out, 1, one-cycle pulse, request accepted
- reject, out, 1, one-cycle pulse, request hit sold-out product
- done, out, 1, one-cycle pulse, sequence complete
- soda_empty, out, 1, soda stock == 0
- diet_empty, out, 1, diet stock == 0

Function
REQ-003 FSM states SHALL be IDLE, MOTOR, GAP, CHANGE, DONE.
REQ-004 In IDLE, a request SHALL be sampled on a rising edge; soda wins if vend_soda and vend_diet are both high, and diet is dropped without ack.
REQ-005 On an accepted request, req_ack SHALL pulse in the following cycle, change_n SHALL be latched, and the FSM SHALL leave IDLE.
REQ-006 Requests arriving while busy SHALL be ignored: no ack, no latch, no queuing.
REQ-007 If the selected product has stock > 0, the FSM SHALL enter MOTOR, decrement that stock by 1 on entry, and hold the matching motor high exactly PULSE_CYC cycles.
REQ-008 If the selected stock == 0, reject SHALL pulse with req_ack, MOTOR SHALL be skipped, and the latched refund count SHALL be change_n + PRICE_N (5-bit, no overflow).
REQ-009 GAP SHALL last exactly 1 cycle with all outputs low except busy.
REQ-010 In CHANGE, nickel_out SHALL toggle 1 cycle high, 1 cycle low per owed nickel; the FSM SHALL go to DONE after the last low cycle, or immediately after 1 cycle if the count is 0.
REQ-011 DONE SHALL last 1 cycle with done high, then return to IDLE; busy SHALL drop in the IDLE cycle.
REQ-012 soda_motor and diet_motor SHALL never be high in the same cycle.
REQ-013 Stock counters SHALL be 4-bit, never decrement below 0, and never wrap.
REQ-014 restock SHALL act only in IDLE, loading both stocks with INIT_STOCK; it SHALL take priority over a same-cycle vend, which is dropped; restock while busy SHALL be ignored.
REQ-015 soda_empty and diet_empty SHALL be combinational from the stock counters.

Reset
REQ-016 When rst is low, the block SHALL immediately, without waiting for a clock, force IDLE, both stocks = INIT_STOCK, and all pulse/motor/nickel outputs and busy = 0.
REQ-017 Reset asserted mid-sequence SHALL abort the sequence at once: motors and nickel_out drop, owed change is discarded, and no done pulse is issued.
REQ-018 After rst is released, the first request SHALL be accepted no earlier than the first rising edge with rst high.

Verification
REQ-019 The bench SHALL cover these scenarios:
- vend_soda, change_n=2 -> ack; soda_motor high 4 cycles; 1 gap cycle; 2 nickel pulses; done; soda stock 8->7.
- vend_soda and vend_diet in the same cycle -> soda path only; diet stock unchanged at 8.
- 8 diet vends, then a 9th with change_n=1 -> diet_empty=1; 9th gives ack+reject, no diet_motor, 6 nickel pulses.
- vend_diet while busy, and restock while busy -> both ignored; restock in IDLE -> both stocks 8, empties clear.
- rst low during the 2nd of 3 nickel pulses -> outputs 0 asynchronously; no done; stocks 8.
- change_n=15 with sold-out product -> 20 nickel pulses, no overflow.
